// File: rtl/bus_cycle_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// bus_cycle_controller : 68000 DTACK/BERR/VPA/IACK sequencing and IPL encoder
// Revision 1.0
// ============================================================================
module bus_cycle_controller #(
  parameter int ROM_WAIT        = 2,
  parameter int RAM_WAIT        = 0,
  parameter int DUART_WAIT      = 3,
  parameter int IO_WAIT         = 0,
  parameter int BERR_TIMEOUT    = 64,
  parameter int DUART_IRQ_LEVEL = 5,
  parameter int EXP_IRQ_LEVEL   = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       AS,
  input  logic       UDS,
  input  logic       LDS,
  input  logic       RW,
  input  logic       FC0,
  input  logic       FC1,
  input  logic       FC2,
  input  logic [3:0] ADDR_H,
  input  logic [2:0] ADDR_L,
  input  logic       BOOT,
  input  logic       DUART_DTACK,
  input  logic       EXP_DTACK,
  input  logic       IRQ_DUART,
  input  logic       IRQ_EXP,
  output logic       DTACK,
  output logic       BERR,
  output logic       VPA,
  output logic       IACK_DUART,
  output logic       IPL0,
  output logic       IPL1,
  output logic       IPL2
);

  localparam logic [7:0] ROM_WAIT_C   = 8'(ROM_WAIT);
  localparam logic [7:0] RAM_WAIT_C   = 8'(RAM_WAIT);
  localparam logic [7:0] DUART_WAIT_C = 8'(DUART_WAIT);
  localparam logic [7:0] IO_WAIT_C    = 8'(IO_WAIT);
  localparam logic [7:0] TIMEOUT_C    = 8'(BERR_TIMEOUT);
  localparam logic [2:0] DUART_LVL    = 3'(DUART_IRQ_LEVEL);
  localparam logic [2:0] EXP_LVL      = 3'(EXP_IRQ_LEVEL);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MEM   = 3'd1,
    S_DUART = 3'd2,
    S_EXT   = 3'd3,
    S_VEC   = 3'd4,
    S_ACK   = 3'd5,
    S_HOLD  = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [7:0] tmo_q, tmo_d;
  logic       dtack_q, dtack_d;
  logic       berr_q, berr_d;
  logic       vpa_q, vpa_d;
  logic       iack_q, iack_d;
  logic [1:0] irq_sync1_q, irq_sync1_d;
  logic [1:0] irq_sync2_q, irq_sync2_d;
  logic [2:0] ipl_q, ipl_d;
  logic [2:0] level;
  logic       cyc_start;
  logic       ready;

  assign cyc_start = !AS && (!UDS || !LDS);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    tmo_d   = tmo_q;
    dtack_d = dtack_q;
    berr_d  = berr_q;
    vpa_d   = vpa_q;
    iack_d  = iack_q;
    ready   = 1'b0;

    case (state_q)
      S_MEM:   ready = (wait_q == 8'd0);
      S_DUART: ready = (wait_q == 8'd0) && !DUART_DTACK;
      S_EXT:   ready = !EXP_DTACK;
      S_VEC:   ready = !DUART_DTACK;
      default: ready = 1'b0;
    endcase

    case (state_q)
      S_IDLE: begin
        if (cyc_start) begin
          tmo_d = 8'd1;
          if (FC2 && FC1 && FC0) begin
            if (ADDR_L == DUART_LVL) begin
              state_d = S_VEC;
              iack_d  = 1'b0;
            end else begin
              state_d = S_HOLD;
              vpa_d   = 1'b0;
            end
          end else if (!BOOT) begin
            state_d = S_MEM;
            wait_d  = ROM_WAIT_C;
          end else if (ADDR_H == 4'b1000 && !RW) begin
            state_d = S_HOLD;
            berr_d  = 1'b0;
          end else if (ADDR_H == 4'b1000) begin
            state_d = S_MEM;
            wait_d  = ROM_WAIT_C;
          end else if (ADDR_H == 4'b0000) begin
            state_d = S_MEM;
            wait_d  = RAM_WAIT_C;
          end else if (ADDR_H == 4'b1111) begin
            state_d = S_MEM;
            wait_d  = IO_WAIT_C;
          end else if (ADDR_H == 4'b1100) begin
            state_d = S_DUART;
            wait_d  = DUART_WAIT_C;
          end else begin
            state_d = S_EXT;
          end
        end
      end

      S_MEM, S_DUART, S_EXT, S_VEC: begin
        if (tmo_q != 8'hFF) tmo_d = tmo_q + 8'd1;
        // Abort beats timeout, and timeout beats a same-edge acknowledge.
        if (AS) begin
          state_d = S_IDLE;
          wait_d  = 8'd0;
          tmo_d   = 8'd0;
          dtack_d = 1'b1;
          berr_d  = 1'b1;
          vpa_d   = 1'b1;
          iack_d  = 1'b1;
        end else if (tmo_q >= TIMEOUT_C) begin
          state_d = S_HOLD;
          berr_d  = 1'b0;
          iack_d  = 1'b1;
        end else if (ready) begin
          state_d = S_ACK;
          dtack_d = 1'b0;
        end else if (wait_q != 8'd0) begin
          wait_d = wait_q - 8'd1;
        end
      end

      S_ACK, S_HOLD: begin
        if (AS) begin
          state_d = S_IDLE;
          wait_d  = 8'd0;
          tmo_d   = 8'd0;
          dtack_d = 1'b1;
          berr_d  = 1'b1;
          vpa_d   = 1'b1;
          iack_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        dtack_d = 1'b1;
        berr_d  = 1'b1;
        vpa_d   = 1'b1;
        iack_d  = 1'b1;
      end
    endcase
  end

  // Interrupt path runs independently of the bus-cycle FSM.
  always_comb begin
    irq_sync1_d = {IRQ_DUART, IRQ_EXP};
    irq_sync2_d = irq_sync1_q;
    level       = 3'd0;
    if (!irq_sync2_q[1] && !irq_sync2_q[0])
      level = (DUART_LVL > EXP_LVL) ? DUART_LVL : EXP_LVL;
    else if (!irq_sync2_q[1])
      level = DUART_LVL;
    else if (!irq_sync2_q[0])
      level = EXP_LVL;
    ipl_d = ~level;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      wait_q      <= 8'd0;
      tmo_q       <= 8'd0;
      dtack_q     <= 1'b1;
      berr_q      <= 1'b1;
      vpa_q       <= 1'b1;
      iack_q      <= 1'b1;
      irq_sync1_q <= 2'b11;
      irq_sync2_q <= 2'b11;
      ipl_q       <= 3'b111;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      tmo_q       <= tmo_d;
      dtack_q     <= dtack_d;
      berr_q      <= berr_d;
      vpa_q       <= vpa_d;
      iack_q      <= iack_d;
      irq_sync1_q <= irq_sync1_d;
      irq_sync2_q <= irq_sync2_d;
      ipl_q       <= ipl_d;
    end
  end

  assign DTACK      = dtack_q;
  assign BERR       = berr_q;
  assign VPA        = vpa_q;
  assign IACK_DUART = iack_q;
  assign IPL2       = ipl_q[2];
  assign IPL1       = ipl_q[1];
  assign IPL0       = ipl_q[0];

endmodule
`default_nettype wire
